// File: rtl/gemm_tile_pkg.sv
// rtl/gemm_tile_pkg.sv - shared types, default widths and product helper for the GEMM tile engine
package gemm_tile_pkg;

  localparam int unsigned DefInDataWidth  = 8;
  localparam int unsigned DefOutDataWidth = 32;
  localparam int unsigned DefTileM        = 4;
  localparam int unsigned DefTileN        = 4;
  localparam int unsigned DefTileK        = 4;
  localparam int unsigned DefKCntWidth    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Full-precision signed product; callers truncate to their accumulator width,
  // which is a sign extension whenever the accumulator is wider than the product.
  function automatic logic signed [63:0] mul_sext(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

endpackage

// File: rtl/tile_dot_acc.sv
// rtl/tile_dot_acc.sv - one output element: TileK-deep dot product feeding a wrapping accumulator
module tile_dot_acc
  import gemm_tile_pkg::*;
#(
  parameter int unsigned InDataWidth  = DefInDataWidth,
  parameter int unsigned OutDataWidth = DefOutDataWidth,
  parameter int unsigned TileK        = DefTileK
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 en_i,
  input  logic                                 first_i,
  input  logic [TileK-1:0][InDataWidth-1:0]    a_i,
  input  logic [TileK-1:0][InDataWidth-1:0]    b_i,
  output logic signed [OutDataWidth-1:0]       acc_o
);

  logic signed [OutDataWidth-1:0] w_sum;
  logic signed [OutDataWidth-1:0] r_acc;

  // Adder tree over the K products, evaluated modulo 2^OutDataWidth
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < int'(TileK); k++) begin
      w_sum = w_sum + OutDataWidth'(mul_sext(32'($signed(a_i[k])), 32'($signed(b_i[k]))));
    end
  end

  // Accumulator: the first beat of a tile overwrites, later beats add on
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else if (en_i) begin
      r_acc <= (first_i ? '0 : r_acc) + w_sum;
    end
  end

  assign acc_o = r_acc;

endmodule

// File: rtl/gemm_tile_engine.sv
// rtl/gemm_tile_engine.sv - output-stationary GEMM tile with K-chunk control and valid/ready handshakes
module gemm_tile_engine
  import gemm_tile_pkg::*;
#(
  parameter int unsigned InDataWidth  = DefInDataWidth,
  parameter int unsigned OutDataWidth = DefOutDataWidth,
  parameter int unsigned TileM        = DefTileM,
  parameter int unsigned TileN        = DefTileN,
  parameter int unsigned TileK        = DefTileK,
  parameter int unsigned KCntWidth    = DefKCntWidth
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic                                                start_i,
  input  logic [KCntWidth-1:0]                                k_steps_i,
  output logic                                                busy_o,
  input  logic signed [TileM-1:0][TileK-1:0][InDataWidth-1:0]  a_data_i,
  input  logic signed [TileK-1:0][TileN-1:0][InDataWidth-1:0]  b_data_i,
  input  logic                                                in_valid_i,
  output logic                                                in_ready_o,
  output logic signed [TileM-1:0][TileN-1:0][OutDataWidth-1:0] c_data_o,
  output logic                                                c_valid_o,
  input  logic                                                c_ready_i
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [KCntWidth-1:0] r_steps;
  logic [KCntWidth-1:0] r_kcnt;
  logic                 r_first;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_launch;

  assign w_accept = in_valid_i && (r_state == ACC);
  assign w_last   = (r_kcnt == r_steps - 1'b1);

  // State register; reset drops c_valid_o/in_ready_o immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; w_launch marks a tile start (from IDLE or back-to-back from DRAIN)
  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    c_valid_o   = 1'b0;
    busy_o      = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = ACC;
          w_launch    = 1'b1;
        end
      end
      ACC: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (w_accept && w_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        c_valid_o = 1'b1;
        busy_o    = 1'b1;
        if (c_ready_i) begin
          if (start_i) begin
            w_state_nxt = ACC;
            w_launch    = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Step count, beat counter and first-beat flag; a zero count is promoted to one beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_steps <= '0;
      r_kcnt  <= '0;
      r_first <= 1'b0;
    end else if (w_launch) begin
      r_steps <= (k_steps_i == '0) ? KCntWidth'(1) : k_steps_i;
      r_kcnt  <= '0;
      r_first <= 1'b1;
    end else if (w_accept) begin
      r_kcnt  <= r_kcnt + 1'b1;
      r_first <= 1'b0;
    end
  end

  for (genvar i = 0; i < int'(TileM); i++) begin : g_row
    for (genvar j = 0; j < int'(TileN); j++) begin : g_pe
      logic [TileK-1:0][InDataWidth-1:0] w_col;
      for (genvar k = 0; k < int'(TileK); k++) begin : g_col
        assign w_col[k] = b_data_i[k][j];
      end
      tile_dot_acc #(
        .InDataWidth (InDataWidth),
        .OutDataWidth(OutDataWidth),
        .TileK       (TileK)
      ) u_pe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_accept),
        .first_i(r_first),
        .a_i    (a_data_i[i]),
        .b_i    (w_col),
        .acc_o  (c_data_o[i][j])
      );
    end
  end

endmodule

// File: doc/gemm_tile_engine.md
Name: gemm_tile_engine

Overview:
- Parametrised output-stationary GEMM tile engine. Computes a TileM x TileN block of C = A x B by accumulating a programmable number of K-chunks, each a TileM x TileK A slice and a TileK x TileN B slice.
- Adds to the earlier fixed-square MAC tile: a start/count control FSM, valid/ready input and output handshakes, and a held result register.
- Sits between the operand buffers and the C writeback path in the gemm datapath.

Parameters:
- InDataWidth, 8, signed operand width.
- OutDataWidth, 32, signed accumulator/result width.
- TileM, 4, output rows.
- TileN, 4, output columns.
- TileK, 4, reduction depth per input beat.
- KCntWidth, 16, width of the K-chunk count.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin a tile; samples k_steps_i.
- k_steps_i  in  KCntWidth  number of K-chunks for this tile (0 treated as 1).
- busy_o  out  1  high in ACC or DRAIN.
- a_data_i  in  [TileM][TileK][InDataWidth] signed  A slice, a_data_i[i][k].
- b_data_i  in  [TileK][TileN][InDataWidth] signed  B slice, b_data_i[k][j].
- in_valid_i  in  1  operand beat valid.
- in_ready_o  out  1  engine accepts a beat.
- c_data_o  out  [TileM][TileN][OutDataWidth] signed  result; c_data_o[i][j] is C[i][j] (natural, non-mirrored indexing).
- c_valid_o  out  1  result valid.
- c_ready_i  in  1  consumer accepts result.

Behaviour:
- Clocking and reset: single clock domain, asynchronous active-low reset. On reset: state=IDLE; all accumulators 0; k counter 0; c_valid_o=0; in_ready_o=0; busy_o=0; c_data_o=0.
- FSM IDLE -> ACC: on start_i. Latch steps = max(k_steps_i, 1). Clear the k counter. Set the first-beat flag.
- ACC:
  - in_ready_o=1. A beat is accepted when in_valid_i && in_ready_o.
  - Per accepted beat, for every (i,j): acc[i][j] <= (first ? 0 : acc[i][j]) + sum over k of a[i][k]*b[k][j]. The accumulator register updates the cycle after acceptance.
  - No update without acceptance; bubbles are allowed.
  - Accepting beat number steps -> DRAIN.
- DRAIN:
  - c_valid_o=1; c_data_o = acc. c_data_o is a direct register view and is stable while c_valid_o && !c_ready_i.
  - in_ready_o=0.
  - On c_valid_o && c_ready_i: if start_i is also high, go directly to ACC with the newly latched count (back-to-back tiles, no idle cycle). Otherwise go to IDLE.
- Latency: result is valid the cycle after the last beat is accepted. Minimum tile time is steps+1 cycles plus the consumer stall.
- Arithmetic:
  - Products are full-precision 2*InDataWidth signed, sign-extended to OutDataWidth.
  - The adder tree is computed in OutDataWidth.
  - Accumulation wraps modulo 2^OutDataWidth; there is no saturation or overflow flag.
- Ignored inputs:
  - start_i in ACC is ignored.
  - start_i in DRAIN without the c handshake is ignored; it is not queued.
  - in_valid_i outside ACC is ignored and leaves operands unconsumed.
- Reset mid-operation: returns to IDLE immediately and discards the partial tile. c_valid_o drops asynchronously.
- busy_o = (state != IDLE).

Decomposition:
- Package gemm_tile_pkg:
  - state enum {IDLE, ACC, DRAIN} as a typedef.
  - Default width localparams.
  - Helper function for product sign-extension.
- Sub-module tile_dot_acc, instantiated TileM*TileN times:
  - Inputs: TileK a/b vectors, en, first.
  - Output: registered OutDataWidth accumulator with asynchronous reset.
- The top level holds the FSM, k counter and handshakes, and builds row/column vectors per PE via generate loops.

Test Plan:
- Identity: A = I (4x4), B[k][j] = 4k+j, k_steps_i=1, in_valid_i held -> c_valid_o high 1 cycle after acceptance; c_data_o[i][j] = 4i+j.
- Multi-step with bubbles: k_steps_i=3; all A=1, all B=2; in_valid_i toggled 1,0,1,0,1 -> exactly 3 beats accepted; every C = 24; c_valid_o only after the 3rd beat.
- Signed and wrap: all A=-128, all B=-128, k_steps_i=1 -> C = 65536. With OutDataWidth=16 -> C = 0 (wraps).
- Backpressure then back-to-back: c_ready_i low for 5 cycles -> c_data_o stable, in_ready_o=0. Then c_ready_i=1 together with start_i=1, k_steps_i=2 -> next cycle ACC with in_ready_o=1; the first new beat overwrites (no carry-over of the old result).
- k_steps_i=0 -> behaves as 1. start_i during ACC -> ignored; the original count still completes.
- Reset mid-ACC after 2 of 4 beats -> outputs zero; a fresh start with k_steps_i=1 yields a single-beat result uncontaminated by the aborted tile.
